// File: rtl/uart_rx_ctrl_if.sv
// Serial-receive bundle between the line/config side and the UART receive controller.
// Latency: none; plain wires grouped for port hygiene.
// Backpressure: none; the serial line and strobes are free-running.
interface uart_rx_ctrl_if;
  logic RX_in;
  logic parity_en;
  logic parity_odd;
  logic rx_bit;
  logic shift;
  logic busy;
  logic rx_done;
  logic parity_err;
  logic frame_err;

  // Line/config driver side.
  modport master (
    output RX_in, parity_en, parity_odd,
    input  rx_bit, shift, busy, rx_done, parity_err, frame_err
  );

  // Receive controller side.
  modport slave (
    input  RX_in, parity_en, parity_odd,
    output rx_bit, shift, busy, rx_done, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 2-flop sync, 16x oversampled start check, mid-bit shift strobes, parity/stop check.
// Latency: rx_bit lags RX_in by 2 clk; rx_done at mid stop bit, 9*16*BAUD_DIV clk after start validation (10x with parity).
// Backpressure: none; the serial line cannot be stalled, so the downstream sipo must take every shift strobe.
module uart_rx_ctrl #(
  parameter int BAUD_DIV = 27,
  parameter int DIV_W    = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_sync;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [3:0]       samp_cnt, samp_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic             par_acc, par_acc_nxt;
  logic             par_bit, par_bit_nxt;
  logic             par_en_l, par_en_nxt;
  logic             par_odd_l, par_odd_nxt;
  logic             armed, armed_nxt;
  logic             parity_err_r, parity_err_nxt;
  logic             frame_err_r, frame_err_nxt;
  logic             shift_c, done_c;
  logic             tick, mid_start, sample_pt;

  assign tick      = (div_cnt == DIV_W'(BAUD_DIV - 1));
  assign mid_start = tick && (samp_cnt == 4'd7);
  assign sample_pt = tick && (samp_cnt == 4'd15);

  // Two-flop synchroniser; idles high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.RX_in;
      rx_sync <= rx_meta;
    end
  end

  // Frame state and counters register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      samp_cnt     <= '0;
      bit_cnt      <= '0;
      par_acc      <= 1'b0;
      par_bit      <= 1'b0;
      par_en_l     <= 1'b0;
      par_odd_l    <= 1'b0;
      armed        <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state        <= state_nxt;
      div_cnt      <= div_nxt;
      samp_cnt     <= samp_nxt;
      bit_cnt      <= bit_cnt_nxt;
      par_acc      <= par_acc_nxt;
      par_bit      <= par_bit_nxt;
      par_en_l     <= par_en_nxt;
      par_odd_l    <= par_odd_nxt;
      armed        <= armed_nxt;
      parity_err_r <= parity_err_nxt;
      frame_err_r  <= frame_err_nxt;
    end
  end

  // Next-state, counter and strobe logic for one frame.
  always_comb begin
    state_nxt      = state;
    div_nxt        = div_cnt;
    samp_nxt       = samp_cnt;
    bit_cnt_nxt    = bit_cnt;
    par_acc_nxt    = par_acc;
    par_bit_nxt    = par_bit;
    par_en_nxt     = par_en_l;
    par_odd_nxt    = par_odd_l;
    armed_nxt      = armed;
    parity_err_nxt = parity_err_r;
    frame_err_nxt  = frame_err_r;
    shift_c        = 1'b0;
    done_c         = 1'b0;

    // Oversample timing only runs inside a frame.
    if (state != IDLE) begin
      div_nxt = tick ? '0 : div_cnt + 1'b1;
      if (tick) samp_nxt = samp_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        div_nxt  = '0;
        samp_nxt = '0;
        // A line held low after a bad stop bit must go high before it can start a frame.
        if (rx_sync) armed_nxt = 1'b1;
        if (armed && !rx_sync) begin
          state_nxt = START;
          armed_nxt = 1'b0;
        end
      end
      START: begin
        if (mid_start) begin
          if (!rx_sync) begin
            state_nxt   = DATA;
            samp_nxt    = '0;
            bit_cnt_nxt = '0;
            par_acc_nxt = 1'b0;
            par_en_nxt  = bus.parity_en;
            par_odd_nxt = bus.parity_odd;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (sample_pt) begin
          shift_c     = 1'b1;
          samp_nxt    = '0;
          par_acc_nxt = par_acc ^ rx_sync;
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nxt = par_en_l ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample_pt) begin
          samp_nxt    = '0;
          par_bit_nxt = rx_sync;
          state_nxt   = STOP;
        end
      end
      STOP: begin
        if (sample_pt) begin
          samp_nxt       = '0;
          done_c         = 1'b1;
          frame_err_nxt  = ~rx_sync;
          parity_err_nxt = par_en_l & (par_acc ^ par_bit ^ par_odd_l);
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes come straight from registered state so sipo samples rx_bit on the same edge;
  // reset masks them so an aborted frame never emits a late strobe.
  assign bus.shift      = shift_c & ~reset;
  assign bus.rx_done    = done_c & ~reset;
  assign bus.busy       = (state != IDLE);
  assign bus.rx_bit     = rx_sync;
  assign bus.parity_err = parity_err_r;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sits directly upstream of the receive shift register (`sipo`). It synchronises the serial line, detects and validates the start bit using 16x oversampling, and issues one mid-bit `shift` strobe per data bit, LSB first. It also presents the synchronised serial bit for the shift register to capture, checks optional parity and the stop bit, and flags frame completion. The `sipo` consumes `shift` and `rx_bit`; `RX_DATA` from `sipo` is valid while `rx_done` is high.

## Interface
- `BAUD_DIV`, default 27: clk cycles per oversample tick; one bit = 16 ticks; minimum 2.
- `DIV_W`, default 8: divider counter width; must satisfy 2^DIV_W >= BAUD_DIV.

- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `RX_in` input 1: asynchronous serial line; idles high.
- `parity_en` input 1: 1 = a parity bit follows the 8 data bits. Sampled at start-bit validation.
- `parity_odd` input 1: 1 = odd parity, 0 = even. Sampled at start-bit validation.
- `rx_bit` output 1: synchronised serial bit; drives `sipo` RX_in.
- `shift` output 1: one-clk strobe at mid data bit; drives `sipo` shift.
- `busy` output 1: high from start-edge detection until return to IDLE.
- `rx_done` output 1: one-clk pulse at mid stop bit.
- `parity_err` output 1: registered; updated at each `rx_done`.
- `frame_err` output 1: registered; updated at each `rx_done`.

## Operation
- Synchroniser: 2-flop chain on `RX_in`; second flop is `rx_bit`. Both flops reset to 1.
- Divider: `div_cnt` counts 0..BAUD_DIV-1. `tick` is high when `div_cnt`==BAUD_DIV-1, then `div_cnt` wraps to 0. The divider is cleared to 0 on entry to START.
- Sample counter `s` (4 bits) increments on `tick` and wraps 15->0. It is cleared on entry to START and at every sample point.
- `armed` flag: set when `rx_bit`==1 in IDLE; cleared on leaving IDLE. It prevents a held-low line from retriggering.
- States:
  - IDLE: if `armed` and `rx_bit`==0, go to START.
  - START: on `tick` with `s`==7 (mid start bit):
    - if `rx_bit`==0, go to DATA, clear `s`, `bit_cnt`=0, latch `parity_en` and `parity_odd`;
    - else (false start) go to IDLE.
  - DATA: on `tick` with `s`==15:
    - assert `shift` for that clk;
    - XOR `rx_bit` into the running parity;
    - increment `bit_cnt`;
    - after the 8th shift, go to PARITY if latched `parity_en`, else STOP.
  - PARITY: on `tick` with `s`==15, capture `rx_bit` and go to STOP.
  - STOP: on `tick` with `s`==15:
    - pulse `rx_done`;
    - `frame_err` = (`rx_bit`==0);
    - `parity_err` = latched `parity_en` & (data XOR parity bit XOR `parity_odd`);
    - go to IDLE.
- `busy` = (state != IDLE).
- `shift` and `rx_bit` change only on clk edges, so `sipo` captures the same value the controller sampled.
- Reset values: `shift`=0, `rx_done`=0, `busy`=0, `parity_err`=0, `frame_err`=0, `rx_bit`=1, state=IDLE, all counters 0, `armed`=0.
- Reset mid-frame aborts immediately. No `shift` or `rx_done` is issued for the aborted frame.
- `parity_en` and `parity_odd` changes mid-frame have no effect.

## Timing
- `RX_in` falling edge to `rx_bit` low: 2 clk. One further clk to enter START.
- Start validation: 8 ticks (8·BAUD_DIV clk) after START entry.
- Data samples are spaced exactly 16·BAUD_DIV clk apart. The first sample is 16 ticks after validation.
- `rx_done`, no parity: 9·16·BAUD_DIV clk after validation. With parity: 10·16·BAUD_DIV clk.
- `shift` count per frame is exactly 8 for a valid start, 0 for a false start.
- Return to IDLE happens at mid stop bit. A following start edge is detected with no dead time beyond `armed` (the line must have been seen high).
- `parity_err` and `frame_err` hold their values until the next `rx_done` or reset.

## Test plan
- BAUD_DIV=4, parity off, send 0xA5 (8N1):
  - exactly 8 `shift` pulses, 64 clk apart;
  - `sipo` RX_DATA=0xA5 at `rx_done`;
  - `parity_err`=0, `frame_err`=0.
- Parity on, even, send 0x3C with parity bit 0 -> `parity_err`=0. Repeat with parity bit 1 -> `parity_err`=1, RX_DATA=0x3C.
- `RX_in` low glitch of 20 clk (BAUD_DIV=4, mid-start at ~35 clk):
  - no `shift`, no `rx_done`;
  - `busy` high, then low ~35 clk later.
- Stop bit driven 0 with `RX_in` held low afterwards:
  - `rx_done` pulse with `frame_err`=1;
  - no new frame until the line goes high, then low again.
- Assert `reset` for 1 clk after the 4th `shift`:
  - all outputs at reset values;
  - the next 0x5A frame is received correctly.
- Two back-to-back frames 0xFF then 0x00, with no idle between the stop bit and the next start:
  - two `rx_done` pulses;
  - RX_DATA 0xFF then 0x00;
  - no errors.
